// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode encoding,
// FSM state type and the default operand width.
package mcycle_pkg;

    localparam int MCYCLE_WIDTH = 32;

    localparam logic MCOP_MUL = 1'b0;
    localparam logic MCOP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

endpackage

// File: rtl/mcycle_addsub.sv
// W-bit adder/subtractor shared by the multiply and divide datapaths.
// carry is the adder carry-out; when subtracting it is 1 exactly when a >= b.
module mcycle_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry
);

    // Two's-complement subtract: a + ~b + 1, carry-out doubles as "no borrow".
    assign {carry, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit with a
// pipeline stall output and a one-cycle Done pulse when results are written.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             op;
    // acc_hi: product upper half / partial remainder; acc_lo: multiplier / dividend->quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_b;
    logic             as_sub;
    logic [WIDTH:0]   as_sum;
    logic             as_carry;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    mcycle_addsub #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a     (as_a),
        .b     (as_b),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        as_a   = {1'b0, acc_hi};
        as_b   = '0;
        as_sub = 1'b0;
        hi_nxt = as_sum[WIDTH:1];
        lo_nxt = {as_sum[0], acc_lo[WIDTH-1:1]};
        if (op == MCOP_DIV) begin
            // Shift the next dividend bit into the remainder, then trial-subtract.
            as_a   = {acc_hi, acc_lo[WIDTH-1]};
            as_b   = {1'b0, opnd};
            as_sub = 1'b1;
            hi_nxt = as_carry ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], as_carry};
        end else if (acc_lo[0]) begin
            as_b = {1'b0, opnd};
        end
    end

    assign Busy = RESETn & (((state == IDLE) & Start) | (state == COMPUTE));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= IDLE;
            count   <= '0;
            op      <= MCOP_MUL;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op     <= MCycleOp;
                        count  <= '0;
                        acc_hi <= '0;
                        acc_lo <= (MCycleOp == MCOP_DIV) ? Operand1 : Operand2;
                        opnd   <= (MCycleOp == MCOP_DIV) ? Operand2 : Operand1;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc_hi <= hi_nxt;
                    acc_lo <= lo_nxt;
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        // Low word is product[W-1:0] or quotient; high word is product upper half or remainder.
                        Result1 <= lo_nxt;
                        Result2 <= hi_nxt;
                        Done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model and timing model.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         Start = 1'b0;
    logic         MCycleOp = 1'b0;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [63:0]  last_res = '0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference result as {Result2, Result1}
    function automatic logic [63:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        if (op == MCOP_MUL) begin
            p = {32'd0, a} * {32'd0, b};
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Called in the cycle the unit is idle; returns one cycle after the Done cycle.
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit keep_start, input bit scramble);
        logic [63:0] exp;
        int busy_cycles;
        int done_cyc;
        exp = model(op, a, b);
        busy_cycles = 1;
        done_cyc = 0;
        Start = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        check("busy_on_start", 64'(Busy), 64'd1);
        for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
            step();
            if (!keep_start) Start = 1'b0;
            if (scramble) begin
                Operand1 = (cyc == 10) ? '0 : $urandom;
                Operand2 = $urandom;
                MCycleOp = 1'($urandom_range(0, 1));
            end
            #1;
            if (cyc == 1) check("hold_on_start", {Result2, Result1}, last_res);
            if (Done) begin
                done_cyc = cyc;
                check("busy_in_done", 64'(Busy), 64'd0);
            end else if (Busy) begin
                busy_cycles++;
            end
        end
        check("done_latency", 64'(done_cyc), 64'(W + 1));
        check("busy_cycles", 64'(busy_cycles), 64'(W + 1));
        check("result", {Result2, Result1}, exp);
        last_res = exp;
        step();
        #1;
        check("done_pulse_end", 64'(Done), 64'd0);
        check("result_hold", {Result2, Result1}, last_res);
    endtask

    initial begin
        int done_count;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rop;

        // Reset with Start high: Start must be ignored.
        RESETn = 1'b0;
        Start = 1'b1;
        step();
        step();
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_results", {Result2, Result1}, 64'd0);
        Start = 1'b0;
        RESETn = 1'b1;
        step();
        check("idle_busy", 64'(Busy), 64'd0);

        run_op(MCOP_MUL, 32'd7, 32'd6, 1'b0, 1'b0);
        run_op(MCOP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(MCOP_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
        run_op(MCOP_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op(MCOP_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);

        // Start held high across two operations: Busy drops only for the Done cycle.
        run_op(MCOP_MUL, 32'd3, 32'd4, 1'b1, 1'b0);
        run_op(MCOP_DIV, 32'd9, 32'd2, 1'b0, 1'b0);

        // Reset in the middle of a computation.
        Start = 1'b1;
        MCycleOp = MCOP_MUL;
        Operand1 = 32'h1234_5678;
        Operand2 = 32'h9ABC_DEF1;
        for (int i = 0; i < 10; i++) begin
            step();
            Start = 1'b0;
        end
        check("pre_rst_busy", 64'(Busy), 64'd1);
        RESETn = 1'b0;
        Start = 1'b1;
        step();
        check("mid_rst_busy", 64'(Busy), 64'd0);
        check("mid_rst_results", {Result2, Result1}, 64'd0);
        check("mid_rst_done", 64'(Done), 64'd0);
        RESETn = 1'b1;
        Start = 1'b0;
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Done) done_count++;
        end
        check("no_done_after_rst", 64'(done_count), 64'd0);
        check("idle_after_rst", 64'(Busy), 64'd0);
        last_res = '0;

        // Randomized operations with a spread of divisor classes.
        for (int n = 0; n < 24; n++) begin
            rop = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = $urandom_range(1, 15);
                2: rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            Start = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
